// File: rtl/bram_access_arbiter_if.sv
// Wishbone slave bus between the user-project interconnect and the BRAM arbiter.
interface bram_access_arbiter_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/bram_access_arbiter.sv
// Round-robin share of a single-port BRAM between the Wishbone slave and one internal
// master; each access holds the BRAM inputs for DELAYS cycles, then acks the owner once.
module bram_access_arbiter #(
   parameter int          ADDR_W  = 22,
   parameter int          DELAYS  = 10,
   parameter logic [7:0]  BASE_HI = 8'h38
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   bram_access_arbiter_if.slave wbs,
   input  logic              m_req_i,
   input  logic              m_we_i,
   input  logic [3:0]        m_sel_i,
   input  logic [ADDR_W-1:0] m_adr_i,
   input  logic [31:0]       m_dat_i,
   output logic              m_gnt_o,
   output logic              m_ack_o,
   output logic [31:0]       m_dat_o,
   output logic              bram_en_o,
   output logic [3:0]        bram_we_o,
   output logic [ADDR_W-1:0] bram_adr_o,
   output logic [31:0]       bram_di_o,
   input  logic [31:0]       bram_do_i,
   output logic              busy_o
);

   if (DELAYS < 1) begin : g_bad_delays
      $error("DELAYS must be >= 1");
   end

   localparam int CNT_W = $clog2(DELAYS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAYS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic {OWN_WB, OWN_M} owner_t;

   state_t            state, state_n;
   owner_t            owner, last_owner;
   logic [CNT_W-1:0]  cnt;
   logic              we_q;
   logic [3:0]        sel_q;
   logic [ADDR_W-1:0] adr_q;
   logic [31:0]       dat_q;
   logic [31:0]       rdata_q;
   logic              mask_wb, mask_m;

   logic wb_req, wb_cand, m_cand, grant, grant_m;
   logic wb_ack, m_ack;
   logic unused_adr;

   // only the window byte and the word-address field of the byte address are decoded
   assign unused_adr = ^wbs.wbs_adr_i;

   assign wb_req  = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:24] == BASE_HI);
   assign wb_cand = wb_req & ~mask_wb;
   assign m_cand  = m_req_i & ~mask_m;

   always_comb begin
      state_n = state;
      grant   = 1'b0;
      grant_m = 1'b0;
      case (state)
         IDLE: begin
            if (wb_cand && m_cand) begin
               grant   = 1'b1;
               grant_m = (last_owner == OWN_WB);
            end else if (wb_cand) begin
               grant   = 1'b1;
            end else if (m_cand) begin
               grant   = 1'b1;
               grant_m = 1'b1;
            end
            if (grant) state_n = BUSY;
         end
         BUSY:    if (cnt == CNT_LAST) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         owner      <= OWN_WB;
         last_owner <= OWN_M;
         we_q       <= 1'b0;
         sel_q      <= '0;
         adr_q      <= '0;
         dat_q      <= '0;
         rdata_q    <= '0;
         mask_wb    <= 1'b0;
         mask_m     <= 1'b0;
      end else begin
         state   <= state_n;
         // the requester just served may still hold stb/req on the following cycle
         mask_wb <= (state == DONE) && (owner == OWN_WB);
         mask_m  <= (state == DONE) && (owner == OWN_M);
         if (state == IDLE && grant) begin
            owner      <= grant_m ? OWN_M : OWN_WB;
            last_owner <= grant_m ? OWN_M : OWN_WB;
            cnt        <= '0;
            we_q       <= grant_m ? m_we_i  : wbs.wbs_we_i;
            sel_q      <= grant_m ? m_sel_i : wbs.wbs_sel_i;
            adr_q      <= grant_m ? m_adr_i : wbs.wbs_adr_i[ADDR_W+1:2];
            dat_q      <= grant_m ? m_dat_i : wbs.wbs_dat_i;
         end
         if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) rdata_q <= bram_do_i;
         end
      end
   end

   assign bram_en_o  = (state == BUSY);
   assign bram_we_o  = (state == BUSY && we_q) ? sel_q : 4'b0;
   assign bram_adr_o = (state == BUSY) ? adr_q : '0;
   assign bram_di_o  = (state == BUSY) ? dat_q : '0;
   assign busy_o     = (state != IDLE);
   assign m_gnt_o    = (state != IDLE) && (owner == OWN_M);

   // an aborted WB cycle (stb/cyc dropped) gets no ack, but the FSM still retires
   assign wb_ack = (state == DONE) && (owner == OWN_WB) && wbs.wbs_cyc_i && wbs.wbs_stb_i;
   assign m_ack  = (state == DONE) && (owner == OWN_M);

   assign wbs.wbs_ack_o = wb_ack;
   assign wbs.wbs_dat_o = (wb_ack && !we_q) ? rdata_q : 32'h0;
   assign m_ack_o       = m_ack;
   assign m_dat_o       = (m_ack && !we_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Scoreboard bench: each issued access pushes its expected ack cycle and data, the
// negedge monitor pops and compares whenever an ack appears.
module tb_bram_access_arbiter;
   localparam int ADDR_W = 22;
   localparam int DELAYS = 10;

   typedef struct { int cyc; logic [31:0] dat; } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_req = 1'b0, m_we = 1'b0;
   logic [3:0] m_sel = '0;
   logic [ADDR_W-1:0] m_adr = '0;
   logic [31:0] m_dat = '0;
   logic m_gnt, m_ack;
   logic [31:0] m_rd;
   logic bram_en;
   logic [3:0] bram_we;
   logic [ADDR_W-1:0] bram_adr;
   logic [31:0] bram_di, bram_do;
   logic busy;

   logic [31:0] mem [0:255];
   int cyc_n = 0;
   int n_chk = 0, n_err = 0;
   int we_cnt = 0;
   logic [3:0] we_last = '0;
   exp_t wb_q[$], m_q[$];

   bram_access_arbiter_if wbs();

   bram_access_arbiter #(.ADDR_W(ADDR_W), .DELAYS(DELAYS), .BASE_HI(8'h38)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wbs.slave),
      .m_req_i(m_req), .m_we_i(m_we), .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
      .m_gnt_o(m_gnt), .m_ack_o(m_ack), .m_dat_o(m_rd),
      .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_adr_o(bram_adr),
      .bram_di_o(bram_di), .bram_do_i(bram_do), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;

   // synchronous BRAM, read-before-write
   always @(posedge clk) begin
      if (bram_en) begin
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_adr[7:0]][8*b +: 8] <= bram_di[8*b +: 8];
         bram_do <= mem[bram_adr[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (bram_we != 4'b0) begin we_cnt++; we_last = bram_we; end
         if (wbs.wbs_ack_o) begin
            if (wb_q.size() == 0) chk("wb_spurious_ack", 32'd1, 32'd0);
            else begin
               e = wb_q.pop_front();
               chk("wb_ack_cyc", 32'(cyc_n), 32'(e.cyc));
               chk("wb_rdata", wbs.wbs_dat_o, e.dat);
            end
         end else chk("wb_dat_idle", wbs.wbs_dat_o, 32'h0);
         if (m_ack) begin
            if (m_q.size() == 0) chk("m_spurious_ack", 32'd1, 32'd0);
            else begin
               e = m_q.pop_front();
               chk("m_ack_cyc", 32'(cyc_n), 32'(e.cyc));
               chk("m_rdata", m_rd, e.dat);
            end
         end else chk("m_dat_idle", m_rd, 32'h0);
      end
   end

   task automatic wait_neg(input int n);
      do @(negedge clk); while (cyc_n < n);
   endtask

   task automatic wb_op(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [31:0] exp_dat, input int lat);
      logic got = 1'b0;
      @(posedge clk); #1;
      wbs.wbs_adr_i = adr; wbs.wbs_we_i = we; wbs.wbs_sel_i = sel; wbs.wbs_dat_i = dat;
      wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1;
      wb_q.push_back('{cyc_n + lat, exp_dat});
      for (int i = 0; i < 80 && !got; i++) begin @(negedge clk); got = wbs.wbs_ack_o; end
      if (!got) chk("wb_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
   endtask

   task automatic m_op(input logic [ADDR_W-1:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [31:0] exp_dat, input int lat);
      logic got = 1'b0;
      @(posedge clk); #1;
      m_adr = adr; m_we = we; m_sel = sel; m_dat = dat; m_req = 1'b1;
      m_q.push_back('{cyc_n + lat, exp_dat});
      for (int i = 0; i < 80 && !got; i++) begin @(negedge clk); got = m_ack; end
      if (!got) chk("m_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      m_req = 1'b0; m_we = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic acc;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      #1;
      mem[3] <= 32'hAAAAAAAA;
      mem[5] <= 32'hDEADBEEF;
      mem[7] <= 32'h01234567;
      mem[9] <= 32'hCAFEF00D;
      wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
      wbs.wbs_sel_i = '0; wbs.wbs_dat_i = '0; wbs.wbs_adr_i = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_en", {31'd0, bram_en}, 32'd0);
      chk("rst_we", {28'd0, bram_we}, 32'd0);
      chk("rst_gnt", {31'd0, m_gnt}, 32'd0);
      chk("rst_ack", {30'd0, wbs.wbs_ack_o, m_ack}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // simultaneous requests right after reset: WB, M, WB
      t = cyc_n + 1;
      fork
         begin
            wb_op(32'h3800_001C, 1'b0, 4'hF, 32'h0, 32'h01234567, 11);
            wb_op(32'h3800_001C, 1'b0, 4'hF, 32'h0, 32'h01234567, 22);
         end
         m_op(22'd5, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 23);
         begin
            wait_neg(t + 12); chk("alt_gnt_t12", {31'd0, m_gnt}, 32'd0);
            wait_neg(t + 13); chk("alt_gnt_t13", {31'd0, m_gnt}, 32'd1);
            wait_neg(t + 23); chk("alt_gnt_t23", {31'd0, m_gnt}, 32'd1);
            wait_neg(t + 24); chk("alt_gnt_t24", {31'd0, m_gnt}, 32'd0);
         end
      join

      // single WB read
      wb_op(32'h3800_0014, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 11);

      // partial write then readback
      we_cnt = 0;
      wb_op(32'h3800_000C, 1'b1, 4'b0011, 32'h12345678, 32'h0, 11);
      chk("wr_we_cycles", 32'(we_cnt), 32'd10);
      chk("wr_we_value", {28'd0, we_last}, 32'h3);
      wb_op(32'h3800_000C, 1'b0, 4'hF, 32'h0, 32'hAAAA5678, 11);

      // M write, then WB sees it
      m_op(22'd9, 1'b1, 4'b1100, 32'h5A5A0000, 32'h0, 11);
      wb_op(32'h3800_0024, 1'b0, 4'hF, 32'h0, 32'h5A5AF00D, 11);

      // out-of-window request is ignored
      @(posedge clk); #1;
      wbs.wbs_adr_i = 32'h3000_0000; wbs.wbs_we_i = 1'b0;
      wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1;
      acc = 1'b0;
      repeat (50) begin @(negedge clk); acc = acc | bram_en | busy | wbs.wbs_ack_o; end
      chk("oow_idle", {31'd0, acc}, 32'd0);
      @(posedge clk); #1;
      wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0;

      // reset in the middle of BUSY (cnt=4)
      @(posedge clk); #1;
      t = cyc_n;
      wbs.wbs_adr_i = 32'h3800_0024; wbs.wbs_we_i = 1'b0;
      wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1;
      repeat (5) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wb_q.push_back('{t + 17, 32'h5A5AF00D});
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_en", {31'd0, bram_en}, 32'd0);
      chk("midrst_ack", {31'd0, wbs.wbs_ack_o}, 32'd0);
      wait_neg(t + 17);
      chk("midrst_ack_t17", {31'd0, wbs.wbs_ack_o}, 32'd1);
      @(posedge clk); #1;
      wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0;

      // WB aborts mid-access, M queued behind it
      @(posedge clk); #1;
      t = cyc_n;
      wbs.wbs_adr_i = 32'h3800_0014; wbs.wbs_we_i = 1'b0;
      wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1;
      repeat (3) @(posedge clk); #1;
      wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0;
      repeat (2) @(posedge clk); #1;
      m_adr = 22'd5; m_we = 1'b0; m_sel = 4'hF; m_req = 1'b1;
      m_q.push_back('{t + 23, 32'hDEADBEEF});
      wait_neg(t + 11); chk("abort_busy_t11", {31'd0, busy}, 32'd1);
      wait_neg(t + 12); chk("abort_busy_t12", {31'd0, busy}, 32'd0);
      chk("abort_gnt_t12", {31'd0, m_gnt}, 32'd0);
      wait_neg(t + 13); chk("abort_gnt_t13", {31'd0, m_gnt}, 32'd1);
      wait_neg(t + 23); chk("abort_mack_t23", {31'd0, m_ack}, 32'd1);
      @(posedge clk); #1;
      m_req = 1'b0;
      repeat (3) @(posedge clk);

      chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
      chk("m_q_empty", 32'(m_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
